// File: rtl/unit_stepper.sv
// unit_stepper: per-frame friendly-unit movement controller, initiator side of the
//   Start/Done/Ack front-line handshake with the front calculator.
// Latency: REQ waits for Done, then 1 ACK + 16 MOVE + 1 SPAWN + 1 FIN cycles per frame.
// Backpressure: one frame tick and one spawn request are buffered; further ones are
//   flagged (overrun sticky, spawnDrop pulse).
// Optional feature macro: UNIT_STEPPER_TIMEOUT_EN adds a 100-cycle REQ timeout and
//   the sticky timeoutErr_o output.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frameTick_i              one-cycle frame start pulse
//   spawnReq_i, spawnType_i  spawn request and unit type (type 00 ignored)
//   Done_i, friendlyFront_i, enemyFront_i   front calculator response
//   Start_o, Ack_o           handshake outputs to the front calculator
//   unitLocFlat_o            slot i location in bits [9i+8:9i]
//   unitTypeFlat_o           slot i type in bits [2i+1:2i], 00 = empty
//   latchedFF_o, latchedEF_o fronts captured this frame
//   busy_o, frameDone_o, spawnDrop_o, overrun_o   status
module unit_stepper #(
  parameter int unsigned SPEED     = 2,
  parameter int unsigned SPAWN_LOC = 500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frameTick_i,
  input  logic         spawnReq_i,
  input  logic [1:0]   spawnType_i,
  input  logic         Done_i,
  input  logic [8:0]   friendlyFront_i,
  input  logic [8:0]   enemyFront_i,
  output logic         Start_o,
  output logic         Ack_o,
  output logic [143:0] unitLocFlat_o,
  output logic [31:0]  unitTypeFlat_o,
  output logic [8:0]   latchedFF_o,
  output logic [8:0]   latchedEF_o,
  output logic         busy_o,
  output logic         frameDone_o,
  output logic         spawnDrop_o,
  output logic         overrun_o
`ifdef UNIT_STEPPER_TIMEOUT_EN
  ,
  output logic         timeoutErr_o
`endif
);

  localparam int NUM_UNITS = 16;

  typedef enum logic [2:0] {IDLE, REQ, ACK, MOVE, SPAWN, FIN} state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [8:0]  loc_q  [NUM_UNITS];
  logic [1:0]  type_q [NUM_UNITS];
  logic [8:0]  lat_ff_q, lat_ef_q;
  logic        start_q, ack_q, busy_q, frame_done_q, spawn_drop_q, overrun_q;
  logic        tick_pend_q, spawn_pend_q;
  logic [1:0]  spawn_type_q;
`ifdef UNIT_STEPPER_TIMEOUT_EN
  logic [6:0]  tmo_cnt_q;
  logic        tmo_err_q;
`endif

  // Next location of the slot currently addressed by idx_q.
  logic [8:0] cur_loc;
  logic [9:0] step_t;
  logic [8:0] mv_loc_d;

  always_comb begin
    cur_loc = loc_q[idx_q];
    step_t  = {1'b0, cur_loc} - 10'(SPEED);
    // Clamp at the enemy front; a unit already at or past it is held, never pushed back.
    if (step_t[9] || (step_t[8:0] < lat_ef_q)) begin
      mv_loc_d = (cur_loc <= lat_ef_q) ? cur_loc : lat_ef_q;
    end else begin
      mv_loc_d = step_t[8:0];
    end
  end

  // Lowest-index empty slot; scanning downward leaves the lowest match last.
  logic       free_found;
  logic [3:0] free_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = 4'd0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (type_q[i] == 2'b00) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      lat_ff_q     <= 9'd0;
      lat_ef_q     <= 9'd0;
      start_q      <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      spawn_drop_q <= 1'b0;
      overrun_q    <= 1'b0;
      tick_pend_q  <= 1'b0;
      spawn_pend_q <= 1'b0;
      spawn_type_q <= 2'b00;
      for (int i = 0; i < NUM_UNITS; i++) begin
        loc_q[i]  <= 9'd0;
        type_q[i] <= 2'b00;
      end
`ifdef UNIT_STEPPER_TIMEOUT_EN
      tmo_cnt_q    <= 7'd0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
      spawn_drop_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (frameTick_i || tick_pend_q) begin
            state_q     <= REQ;
            start_q     <= 1'b1;
            busy_q      <= 1'b1;
            tick_pend_q <= 1'b0;
`ifdef UNIT_STEPPER_TIMEOUT_EN
            tmo_cnt_q   <= 7'd0;
`endif
          end
        end
        REQ: begin
          if (Done_i) begin
            lat_ff_q <= friendlyFront_i;
            lat_ef_q <= enemyFront_i;
            start_q  <= 1'b0;
            ack_q    <= 1'b1;
            state_q  <= ACK;
          end
`ifdef UNIT_STEPPER_TIMEOUT_EN
          else if (tmo_cnt_q == 7'd99) begin
            // 100th REQ cycle without Done: abandon the handshake, keep the table as is.
            start_q   <= 1'b0;
            tmo_err_q <= 1'b1;
            state_q   <= SPAWN;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 7'd1;
          end
`endif
        end
        ACK: begin
          idx_q   <= 4'd0;
          state_q <= MOVE;
        end
        MOVE: begin
          if (type_q[idx_q] != 2'b00) begin
            loc_q[idx_q] <= mv_loc_d;
          end
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_q <= SPAWN;
          end
        end
        SPAWN: begin
          if (spawn_pend_q) begin
            if (free_found) begin
              loc_q[free_idx]  <= 9'(SPAWN_LOC);
              type_q[free_idx] <= spawn_type_q;
            end else begin
              spawn_drop_q <= 1'b1;
            end
          end
          spawn_pend_q <= 1'b0;
          frame_done_q <= 1'b1;
          state_q      <= FIN;
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // A tick while busy is buffered once; a tick finding the buffer full is lost.
      if (frameTick_i) begin
        if (tick_pend_q) begin
          overrun_q <= 1'b1;
        end
        if (state_q != IDLE) begin
          tick_pend_q <= 1'b1;
        end
      end

      // Placed after the FSM so a request in the SPAWN cycle survives the clear there.
      if (spawnReq_i && (spawnType_i != 2'b00)) begin
        spawn_pend_q <= 1'b1;
        spawn_type_q <= spawnType_i;
        if (spawn_pend_q && (state_q != SPAWN)) begin
          spawn_drop_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    unitLocFlat_o  = '0;
    unitTypeFlat_o = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unitLocFlat_o[9*i +: 9]  = loc_q[i];
      unitTypeFlat_o[2*i +: 2] = type_q[i];
    end
  end

  assign Start_o     = start_q;
  assign Ack_o       = ack_q;
  assign latchedFF_o = lat_ff_q;
  assign latchedEF_o = lat_ef_q;
  assign busy_o      = busy_q;
  assign frameDone_o = frame_done_q;
  assign spawnDrop_o = spawn_drop_q;
  assign overrun_o   = overrun_q;
`ifdef UNIT_STEPPER_TIMEOUT_EN
  assign timeoutErr_o = tmo_err_q;
`endif

endmodule
